// File: rtl/serial_addsub_moore_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_moore_if
//  Description : Operand/result bundle for the bit-serial adder/subtractor.
//                The master supplies operands and the start request; the
//                slave (the arithmetic block) returns status and results.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_addsub_moore_if #(
    parameter int N = 8
);
    logic         start;
    logic         sub;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, A, B,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_addsub_moore.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_moore
//  Description : N-bit bit-serial adder/subtractor. Operands are captured on
//                start, processed LSB-first one bit per clock through a
//                four-state Moore carry/sum machine, and the result is
//                reported with sum, carry-out, signed overflow and a
//                one-cycle done pulse. Subtraction is A + ~B + 1.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_addsub_moore #(
    parameter int N = 8
) (
    input  logic                 clock,
    input  logic                 resetn,   // active-high synchronous reset
    serial_addsub_moore_if.slave bus
);

    // Counter must hold N+1: the Moore output lags one cycle, so one extra
    // shift is needed to push the last sum bit into place.
    localparam int                 c_cnt_w    = $clog2(N + 2);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(N + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_t;

    // Encoding is {carry, s} so both outputs read directly off the state.
    typedef enum logic [1:0] {
        G0 = 2'b00,
        G1 = 2'b01,
        H0 = 2'b10,
        H1 = 2'b11
    } moore_t;

    ctrl_t               r_ctrl;
    ctrl_t               w_ctrl_nxt;
    moore_t              r_moore;
    moore_t              w_moore_nxt;
    logic [N-1:0]        r_qa;
    logic [N-1:0]        r_qb;
    logic [N-1:0]        r_sum;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_cout;
    logic                r_ovf;
    logic                r_as;
    logic                r_bs;

    logic                w_load;
    logic                w_shift;
    logic                w_last;
    logic                w_carry;
    logic                w_s;
    logic [1:0]          w_total;
    logic [N-1:0]        w_b_eff;

    assign w_carry = r_moore[1];
    assign w_s     = r_moore[0];
    assign w_total = {1'b0, w_carry} + {1'b0, r_qa[0]} + {1'b0, r_qb[0]};
    assign w_b_eff = bus.sub ? ~bus.B : bus.B;

    // Next-state logic for both the control FSM and the Moore adder FSM
    always_comb begin
        w_ctrl_nxt  = r_ctrl;
        w_moore_nxt = r_moore;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        case (r_ctrl)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_ctrl_nxt  = RUN;
                    w_moore_nxt = bus.sub ? H0 : G0;   // carry-in = sub
                end else if (r_ctrl == DONE) begin
                    w_ctrl_nxt  = IDLE;
                end
            end
            RUN: begin
                w_shift     = 1'b1;
                w_moore_nxt = moore_t'(w_total);
                if (r_cnt == c_cnt_one) begin
                    w_last     = 1'b1;
                    w_ctrl_nxt = DONE;
                end
            end
            default: begin
                w_ctrl_nxt = IDLE;
            end
        endcase
    end

    // State registers for the control and Moore FSMs
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_ctrl  <= IDLE;
            r_moore <= G0;
        end else begin
            r_ctrl  <= w_ctrl_nxt;
            r_moore <= w_moore_nxt;
        end
    end

    // Operand shifters, sum shifter, bit counter and result flags
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_qa   <= '0;
            r_qb   <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_as   <= 1'b0;
            r_bs   <= 1'b0;
        end else if (w_load) begin
            r_qa  <= bus.A;
            r_qb  <= w_b_eff;
            r_cnt <= c_cnt_load;
            r_as  <= bus.A[N-1];
            r_bs  <= w_b_eff[N-1];
        end else if (w_shift) begin
            r_qa  <= {1'b0, r_qa[N-1:1]};
            r_qb  <= {1'b0, r_qb[N-1:1]};
            r_sum <= {w_s, r_sum[N-1:1]};
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                // On the final shift the operand bits are exhausted, so the
                // current state still holds the carry out of bit N-1 and its
                // s is the bit landing in sum[N-1].
                r_cout <= w_carry;
                r_ovf  <= (r_as == r_bs) && (w_s != r_as);
            end
        end
    end

    assign bus.busy = (r_ctrl == RUN);
    assign bus.done = (r_ctrl == DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_moore.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub_moore
//  Description : Self-checking bench for serial_addsub_moore (N=8 and N=4)
//                against an integer-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_addsub_moore;

    logic clock;
    logic resetn;
    int   n_vectors;
    int   n_miscompares;

    serial_addsub_moore_if #(.N(8)) bus8 ();
    serial_addsub_moore_if #(.N(4)) bus4 ();

    serial_addsub_moore #(.N(8)) dut8 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus8)
    );

    serial_addsub_moore #(.N(4)) dut4 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for every check in the bench
    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers of width w
    function automatic void ref_model(input int a, input int b, input int w, input bit s,
                                      output int es, output bit ec, output bit eo);
        int m, sa, sb, ur, sr;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (s) begin
            ur = a - b;
            sr = sa - sb;
            ec = (a >= b);
        end else begin
            ur = a + b;
            sr = sa + sb;
            ec = (ur >= m);
        end
        es = ((ur % m) + m) % m;
        eo = (sr >= m / 2) || (sr < -(m / 2));
    endfunction

    // One N=8 operation; caller is #1 after a rising edge. b2b leaves the
    // bench in the done cycle so the next call restarts immediately.
    // glitch (nonzero) pulses start with junk operands in that RUN cycle.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input bit b2b, input int glitch);
        int es;
        bit ec, eo;
        int cyc;
        bit busy_ok;
        ref_model(int'(a), int'(b), 8, s, es, ec, eo);
        bus8.start = 1'b1;
        bus8.A     = a;
        bus8.B     = b;
        bus8.sub   = s;
        @(posedge clock); #1;
        bus8.start = 1'b0;
        bus8.A     = 8'($urandom);
        bus8.B     = 8'($urandom);
        bus8.sub   = 1'($urandom);
        cyc     = 0;
        busy_ok = 1'b1;
        while (!bus8.done && cyc < 20) begin
            if (!bus8.busy) busy_ok = 1'b0;
            bus8.start = (glitch != 0 && cyc == glitch);
            @(posedge clock); #1;
            cyc++;
        end
        bus8.start = 1'b0;
        check_value("latency8", 64'(cyc), 64'd9);
        check_value("busy_run8", 64'(busy_ok), 64'd1);
        check_value("busy_done8", 64'(bus8.busy), 64'd0);
        check_value("sum8", 64'(bus8.sum), 64'(es));
        check_value("cout8", 64'(bus8.cout), 64'(ec));
        check_value("ovf8", 64'(bus8.ovf), 64'(eo));
        if (!b2b) begin
            @(posedge clock); #1;
            check_value("done_pulse8", 64'(bus8.done), 64'd0);
            check_value("idle_busy8", 64'(bus8.busy), 64'd0);
            check_value("sum_hold8", 64'(bus8.sum), 64'(es));
        end
    endtask

    // One N=4 operation
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int es;
        bit ec, eo;
        int cyc;
        ref_model(int'(a), int'(b), 4, s, es, ec, eo);
        bus4.start = 1'b1;
        bus4.A     = a;
        bus4.B     = b;
        bus4.sub   = s;
        @(posedge clock); #1;
        bus4.start = 1'b0;
        cyc = 0;
        while (!bus4.done && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_value("latency4", 64'(cyc), 64'd5);
        check_value("sum4", 64'(bus4.sum), 64'(es));
        check_value("cout4", 64'(bus4.cout), 64'(ec));
        check_value("ovf4", 64'(bus4.ovf), 64'(eo));
        @(posedge clock); #1;
        check_value("done_pulse4", 64'(bus4.done), 64'd0);
    endtask

    // Main stimulus sequence
    initial begin
        bit saw_done;
        n_vectors     = 0;
        n_miscompares = 0;
        resetn     = 1'b1;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.A = '0; bus8.B = '0;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.A = '0; bus4.B = '0;
        repeat (3) @(posedge clock);
        #1;
        check_value("rst_busy", 64'(bus8.busy), 64'd0);
        check_value("rst_done", 64'(bus8.done), 64'd0);
        check_value("rst_sum", 64'(bus8.sum), 64'd0);
        check_value("rst_cout", 64'(bus8.cout), 64'd0);
        check_value("rst_ovf", 64'(bus8.ovf), 64'd0);
        check_value("rst_sum4", 64'(bus4.sum), 64'd0);
        resetn = 1'b0;
        @(posedge clock); #1;

        // Directed vectors
        run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op8(8'h10, 8'h20, 1'b1, 1'b0, 0);
        run_op8(8'h80, 8'h01, 1'b1, 1'b0, 0);
        run_op8(8'h00, 8'h00, 1'b1, 1'b0, 0);
        run_op8(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op8(8'h80, 8'h80, 1'b0, 1'b0, 0);

        // Back-to-back restart in the done cycle
        run_op8(8'hFF, 8'h01, 1'b0, 1'b1, 0);
        run_op8(8'h01, 8'h01, 1'b0, 1'b0, 0);

        // Start pulse during RUN must be ignored
        run_op8(8'h33, 8'h44, 1'b0, 1'b0, 3);

        // Reset in the middle of RUN with start held high
        bus8.start = 1'b1; bus8.A = 8'hC3; bus8.B = 8'h5A; bus8.sub = 1'b0;
        @(posedge clock); #1;
        repeat (3) begin @(posedge clock); #1; end
        resetn = 1'b1;
        @(posedge clock); #1;
        check_value("abort_busy", 64'(bus8.busy), 64'd0);
        check_value("abort_sum", 64'(bus8.sum), 64'd0);
        check_value("abort_done", 64'(bus8.done), 64'd0);
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clock); #1;
            if (bus8.done || bus8.busy) saw_done = 1'b1;
        end
        check_value("abort_quiet", 64'(saw_done), 64'd0);
        resetn = 1'b0;
        run_op8(8'h21, 8'h12, 1'b1, 1'b0, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            bit         rb2b;
            int         rg;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rs   = 1'($urandom);
            rb2b = (i != 39) && ($urandom_range(0, 1) == 1);
            rg   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            run_op8(ra, rb, rs, rb2b, rg);
        end

        // N=4 instance
        run_op4(4'h7, 4'h1, 1'b0);
        run_op4(4'h3, 4'h5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op4(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_addsub_moore.md
# serial_addsub_moore

Parametrised bit-serial adder/subtractor built around a four-state Moore carry/sum FSM, the N-bit, two-mode successor to the fixed 4-bit serial adder. It captures two N-bit operands on a start handshake, processes one bit per clock LSB-first, and reports sum, carry-out and signed overflow with a single-cycle done pulse. It sits between a parallel operand source and a result consumer where area matters more than latency.

## Interface
- N, default 8, operand/result width in bits; legal range 2..32.
- clock  in  1  sole clock; all state changes on its rising edge.
- resetn  in  1  synchronous, active-high reset despite the name; a 1 sampled at a rising edge resets the block.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  mode, captured with start: 0 = A+B, 1 = A−B.
- A  in  N  operand A, captured with start.
- B  in  N  operand B, captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; sum/cout/ovf valid.
- sum  out  N  result, two's-complement/unsigned agnostic.
- cout  out  1  carry out of bit N−1; for sub, 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  signed two's-complement overflow.

## Operation
- Control FSM: IDLE → RUN → DONE → IDLE.
- IDLE, start=1: load shift register QA←A, QB←(sub ? ~B : B); bit counter←N+1; Moore FSM←initial state; latch sign bits a_s=A[N−1], b_s=(sub ? ~B[N−1] : B[N−1]); go to RUN.
- Moore adder states (carry, s): G0=(0,0), G1=(0,1), H0=(1,0), H1=(1,1). s and carry are functions of state only. Initial state G0 if sub=0, H0 if sub=1 (carry-in = sub).
- Next state from current carry c and LSBs QA[0], QB[0]: total t=c+QA[0]+QB[0]; next = (t[1], t[0]), i.e. G0/G1/H0/H1 for t=0/1/2/3.
- RUN, each cycle: QA, QB shift right (0 in at MSB); Moore FSM advances; sum register shifts right with current-state s entering at bit N−1; counter decrements. Because the output is Moore (one cycle lag), N+1 shifts are needed; the first bit shifted in (initial state's s=0) falls off bit 0.
- When counter reaches 0 after the (N+1)th shift: go to DONE. cout = carry of the final Moore state; ovf = (a_s == b_s) && (sum[N−1] != a_s).
- DONE: done=1 for one cycle, busy=0; start is accepted in this cycle exactly as in IDLE (back-to-back operation).
- start while busy: ignored, not queued.
- Arithmetic: sum = (A + (sub ? ~B : B) + sub) mod 2^N; no saturation.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; control FSM IDLE, Moore FSM G0, counter 0.
- Reset has priority over start in the same cycle; reset mid-RUN aborts with no done pulse and outputs zeroed at that edge.
- Start accepted at edge k: busy=1 after edge k through edge k+N+1; done=1 between edges k+N+1 and k+N+2. Latency N+1 cycles; throughput one result per N+2 cycles (N+1 with back-to-back start in DONE).
- sum, cout, ovf stable from the done cycle until the edge that accepts the next start; during RUN sum is partial and must not be consumed.
- cout/ovf updated only at the RUN→DONE edge.

## Test plan
- N=8, A=8'h5A, B=8'h3C, sub=0 → done exactly 9 cycles after start edge, sum=8'h96, cout=0, ovf=1.
- N=8, A=8'h10, B=8'h20, sub=1 → sum=8'hF0, cout=0, ovf=0; A=8'h80, B=8'h01, sub=1 → sum=8'h7F, cout=1, ovf=1.
- N=8, A=8'hFF, B=8'h01, sub=0 → sum=8'h00, cout=1, ovf=0; immediately restart in done cycle with A=8'h01, B=8'h01 → second done 9 cycles later, sum=8'h02.
- Assert resetn at cycle 4 of RUN while start held high → busy=0, sum=0, no done pulse; block stays IDLE until reset deasserted, then accepts start.
- Pulse start with new operands during RUN → ignored; first result unchanged, busy timing unchanged.
- N=4 instance, A=4'h7, B=4'h1, sub=0 → done 5 cycles after start edge, sum=4'h8, cout=0, ovf=1.
